// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad and emits debounced key events
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst        synchronous reset, active-high
//   row_n[3:0] keypad rows, active-low, asynchronous to clk
//   col_n[3:0] keypad column drive, one-cold
//   key_code   {row_idx, col_idx} of the last accepted key
//   key_valid  one-cycle pulse when a press is accepted
//   key_held   high from the key_valid cycle until the release is accepted
module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_s;
    logic [DIV_W-1:0] r_div_cnt;
    state_t           r_state;
    logic [3:0]       r_col_n;
    logic [1:0]       r_cand_row;
    logic [1:0]       r_cand_col;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [DEB_W-1:0] r_rel_cnt;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;

    logic             w_tick;
    logic             w_single;
    logic             w_idle;
    logic [1:0]       w_row_idx;
    logic [1:0]       w_col_idx;
    logic [3:0]       w_col_next;
    logic [DEB_W-1:0] w_deb_next;
    logic [DEB_W-1:0] w_rel_next;

    always_comb begin
        w_tick     = r_div_cnt == DIV_LAST;
        w_single   = r_row_s == 4'b1110 || r_row_s == 4'b1101 ||
                     r_row_s == 4'b1011 || r_row_s == 4'b0111;
        w_idle     = r_row_s == 4'b1111;
        w_row_idx  = !r_row_s[0] ? 2'd0 : !r_row_s[1] ? 2'd1 : !r_row_s[2] ? 2'd2 : 2'd3;
        w_col_idx  = !r_col_n[0] ? 2'd0 : !r_col_n[1] ? 2'd1 : !r_col_n[2] ? 2'd2 : 2'd3;
        // rotate the single low bit upwards: 1110 -> 1101 -> 1011 -> 0111 -> 1110
        w_col_next = {r_col_n[2:0], r_col_n[3]};
        w_deb_next = r_deb_cnt + DEB_W'(1);
        w_rel_next = r_rel_cnt + DEB_W'(1);
    end

    // two-flop synchroniser; idle (all high) is the reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= 4'b1111;
            r_row_s    <= 4'b1111;
        end else begin
            r_row_meta <= row_n;
            r_row_s    <= r_row_meta;
        end
    end

    // free-running dwell counter, independent of the FSM state
    always_ff @(posedge clk) begin
        if (rst)
            r_div_cnt <= '0;
        else
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SCAN;
            r_col_n     <= 4'b1110;
            r_cand_row  <= '0;
            r_cand_col  <= '0;
            r_deb_cnt   <= '0;
            r_rel_cnt   <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    S_SCAN: begin
                        if (w_single) begin
                            r_cand_row <= w_row_idx;
                            r_cand_col <= w_col_idx;
                            r_deb_cnt  <= DEB_W'(1);
                            r_state    <= S_DEBOUNCE;
                        end else begin
                            r_col_n <= w_col_next;
                        end
                    end
                    S_DEBOUNCE: begin
                        // column is frozen here, so a matching row means the same key
                        if (w_single && w_row_idx == r_cand_row) begin
                            r_deb_cnt <= w_deb_next;
                            if (w_deb_next == DEB_DONE) begin
                                r_state     <= S_PRESSED;
                                r_key_code  <= {r_cand_row, r_cand_col};
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                            end
                        end else begin
                            r_state <= S_SCAN;
                            r_col_n <= w_col_next;
                        end
                    end
                    S_PRESSED: begin
                        if (w_idle) begin
                            r_rel_cnt <= DEB_W'(1);
                            r_state   <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        if (w_idle) begin
                            r_rel_cnt <= w_rel_next;
                            if (w_rel_next == DEB_DONE) begin
                                r_state    <= S_SCAN;
                                r_key_held <= 1'b0;
                                r_col_n    <= w_col_next;
                            end
                        end else begin
                            r_state <= S_PRESSED;
                        end
                    end
                    default: r_state <= S_SCAN;
                endcase
            end
        end
    end

    assign col_n     = r_col_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed test of keypad_scanner with SCAN_DIV=4, DEBOUNCE_CNT=3
module tb_keypad_scanner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    wire  [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic       key_on    = 1'b0;
    logic [3:0] key_col_n = 4'b1101;
    logic [3:0] key_rows  = 4'b1011;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int nvalid   = 0;
    int last_valid = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // keypad model: the pressed switch shorts its rows to the driven column
    assign row_n = (key_on && col_n == key_col_n) ? key_rows : 4'hF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (key_valid === 1'b1) begin
            nvalid++;
            last_valid = cyc;
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        nvalid = 0;
        last_valid = 0;
    endtask

    initial begin
        // 1: idle rotation
        key_on = 1'b0;
        do_reset();
        check("rst_col", col_n, 4'b1110);
        check("rst_code", key_code, 0);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        run_to(3);  check("idle_c3", col_n, 4'b1110);
        run_to(4);  check("idle_c4", col_n, 4'b1101);
        run_to(8);  check("idle_c8", col_n, 4'b1011);
        run_to(12); check("idle_c12", col_n, 4'b0111);
        run_to(16); check("idle_c16", col_n, 4'b1110);
        run_to(20);
        check("idle_nvalid", nvalid, 0);
        check("idle_held", key_held, 0);

        // 2: row 2 on column 1
        key_col_n = 4'b1101; key_rows = 4'b1011; key_on = 1'b1;
        do_reset();
        run_to(15); check("press_early", nvalid, 0);
        run_to(16);
        check("press_valid", key_valid, 1);
        check("press_code", key_code, 4'h9);
        check("press_held", key_held, 1);
        run_to(17); check("press_pulse", key_valid, 0);
        run_to(40);
        check("hold_nvalid", nvalid, 1);
        check("hold_col", col_n, 4'b1101);
        check("hold_held", key_held, 1);

        // 4: release glitch after 2 ticks, then full release
        key_on = 1'b0;
        run_to(49);
        key_on = 1'b1;
        run_to(60);
        check("glitch_held", key_held, 1);
        check("glitch_nvalid", nvalid, 1);
        key_on = 1'b0;
        run_to(71); check("rel_held71", key_held, 1);
        run_to(72);
        check("rel_held72", key_held, 0);
        check("rel_col", col_n, 4'b1011);
        key_on = 1'b1;
        run_to(96);
        check("repress_nvalid", nvalid, 2);
        check("repress_when", last_valid, 96);
        check("repress_code", key_code, 4'h9);

        // 3: bounce at the second debounce tick
        key_on = 1'b1;
        do_reset();
        run_to(9);
        key_on = 1'b0;
        run_to(11); check("bounce_c11", col_n, 4'b1101);
        run_to(12); check("bounce_c12", col_n, 4'b1011);
        run_to(30);
        check("bounce_nvalid", nvalid, 0);
        check("bounce_held", key_held, 0);

        // 5: two rows low on column 0
        key_col_n = 4'b1110; key_rows = 4'b1001; key_on = 1'b1;
        do_reset();
        run_to(3);  check("multi_c3", col_n, 4'b1110);
        run_to(4);  check("multi_c4", col_n, 4'b1101);
        run_to(16); check("multi_c16", col_n, 4'b1110);
        run_to(20); check("multi_c20", col_n, 4'b1101);
        run_to(40); check("multi_nvalid", nvalid, 0);

        // 6a: reset mid-DEBOUNCE
        key_col_n = 4'b1101; key_rows = 4'b1011; key_on = 1'b1;
        do_reset();
        run_to(10);
        check("mdeb_col", col_n, 4'b1101);
        rst = 1'b1;
        step();
        check("mdeb_rcol", col_n, 4'b1110);
        check("mdeb_rvalid", key_valid, 0);
        check("mdeb_rheld", key_held, 0);
        check("mdeb_rcode", key_code, 0);
        rst = 1'b0;
        nvalid = 0;
        repeat (10) step();
        check("mdeb_nvalid", nvalid, 0);

        // 6b: reset mid-PRESSED
        do_reset();
        run_to(20);
        check("mpr_held", key_held, 1);
        check("mpr_code", key_code, 4'h9);
        rst = 1'b1;
        step();
        check("mpr_rcol", col_n, 4'b1110);
        check("mpr_rvalid", key_valid, 0);
        check("mpr_rheld", key_held, 0);
        check("mpr_rcode", key_code, 0);
        rst = 1'b0;
        nvalid = 0;
        repeat (10) step();
        check("mpr_nvalid", nvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x4 matrix keypad and feeds debounced key events to calculator_top. It sits directly upstream of calculator_top, between the keypad pins and the calculator's key input.
- Drives one column low at a time and reads the four row lines, which are externally pulled up and active-low.
- Synchronises and debounces the row lines.
- Emits a one-cycle key_valid pulse with a 4-bit key_code per distinct press; a held key is reported once only.

Parameters:
SCAN_DIV, 1000, clock cycles each column is driven (dwell); rows are sampled on the last cycle of each dwell; minimum 4.
DEBOUNCE_CNT, 4, consecutive identical samples needed to accept a press or a release; minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
row_n  input  4  keypad rows, active-low, asynchronous to clk.
col_n  output  4  keypad column drive, one-cold (exactly one bit 0).
key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the accepted key; stable until the next accepted key.
key_valid  output  1  one-cycle pulse when a press is accepted.
key_held  output  1  high from the key_valid cycle until the release is accepted.

Behaviour:
- Reset values: col_n=4'b1110, key_code=0, key_valid=0, key_held=0, state=SCAN, all counters 0, synchroniser flops 4'b1111.
- Synchroniser: row_n passes through 2 flops giving row_s; all decisions use row_s only.
- Dwell counter div_cnt: counts 0..SCAN_DIV-1 and wraps. tick = (div_cnt==SCAN_DIV-1). The counter runs in every state.
- Column rotation: 1110 -> 1101 -> 1011 -> 0111 -> 1110. col_idx = position of the 0 bit. Rotation happens only where stated below.
- "single" = exactly one bit of row_s low; row_idx = that bit's index.
- SCAN state, on tick:
  - single: latch row_idx/col_idx into cand, deb_cnt=1, go to DEBOUNCE. Column does not rotate.
  - otherwise (no key, or 2+ rows low): rotate column, stay in SCAN.
- DEBOUNCE state, on tick:
  - single with the same row_idx: deb_cnt+1. If the new count equals DEBOUNCE_CNT, go to PRESSED, key_code<=cand, key_valid=1 for the next cycle only, key_held=1.
  - any other pattern: go to SCAN, rotate column, no output.
- PRESSED state, on tick:
  - row_s==4'b1111: go to RELEASE, rel_cnt=1.
  - otherwise: stay. Extra keys pressed meanwhile are ignored; no second key_valid.
- RELEASE state, on tick:
  - row_s==4'b1111: rel_cnt+1. At DEBOUNCE_CNT: go to SCAN, key_held=0, rotate column.
  - any row low: return to PRESSED, no new key_valid (bounce).
- Latency: key_valid is asserted the cycle after the DEBOUNCE_CNT-th consecutive qualifying tick. The first qualifying tick is the SCAN detection tick.
- Key held forever: exactly one key_valid; key_held stays 1; column stays fixed.
- Same key pressed again after release: new key_valid only after a full release debounce and a new press debounce.
- rst asserted in any state: next cycle shows the reset values. A partial debounce is discarded, and no key_valid is issued during or immediately after reset.
- col_n is always one-cold. Never all-high, never two bits low.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
1. Reset, no keys (row_n=4'hF) -> col_n rotates every 4 cycles (1110,1101,1011,0111,1110); key_valid never 1; key_held=0.
2. Hold row 2 on column 1 (row_n=4'b1011 while col_n=4'b1101, else 4'hF) -> one key_valid with key_code=4'h9, one cycle after the 3rd consecutive tick on column 1. key_held=1 and col_n stays 4'b1101 while held.
3. Bounce: same key, but row_n reverts to 4'hF at the 2nd debounce tick -> no key_valid; scanning resumes at column 2.
4. Release: after (2), set row_n=4'hF for 3 ticks -> key_held falls; rotation resumes. A release glitch after 2 ticks returns to PRESSED with no new pulse.
5. Two rows low in one column (row_n=4'b1001 on column 0) -> no key_valid; scanning continues past column 0.
6. rst pulsed for 1 cycle mid-DEBOUNCE and mid-PRESSED -> outputs return to reset values next cycle; no spurious key_valid.
